cmp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one unsigned N-bit magnitude comparator among NREQ requesters. Each requester presents an operand pair and a request. The arbiter grants one requester, captures its operands into registers, evaluates them, and returns registered lesser/greater/equal flags with a one-hot completion pulse. It sits between the requesting datapath blocks and the single shared compare resource.

---
 rtl/cmp_arbiter_if.sv | 26 ++
 rtl/cmp_arbiter.sv | 121 ++++++++++++
 tb/tb_cmp_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the requesting datapath blocks and cmp_arbiter.
// master = requester side, slave = arbiter side.
interface cmp_arbiter_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_in;
    logic [NREQ*N-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              lesser;
    logic              greater;
    logic              equal;
    logic              busy;

    modport master (
        output req, a_in, b_in,
        input  gnt, done, lesser, greater, equal, busy
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, done, lesser, greater, equal, busy
    );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among NREQ requesters.
// Sequence per request: IDLE (capture) -> CMP (gnt, evaluate) -> RESP (done, flags valid).
module cmp_arbiter #(
    parameter int unsigned N    = 16,
    parameter int unsigned NREQ = 4
) (
    input  logic        clk,
    input  logic        rst,
    cmp_arbiter_if.slave bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  win;
    logic [IDW-1:0]  ptr_next;
    logic            found;
    logic [N-1:0]    op_a;
    logic [N-1:0]    op_b;
    logic [N-1:0]    a_arr [NREQ];
    logic [N-1:0]    b_arr [NREQ];
    logic [NREQ-1:0] gnt_d;
    logic [NREQ-1:0] done_d;
    logic            busy_d;
    int unsigned     idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = bus.a_in[g*N +: N];
        assign b_arr[g] = bus.b_in[g*N +: N];
    end

    // First requester found searching ptr, ptr+1, ... modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign ptr_next = (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (found) state_next = CMP;
            CMP:     state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs
    always_comb begin
        gnt_d  = '0;
        done_d = '0;
        busy_d = (state_next != IDLE);
        if (state == IDLE && state_next == CMP) begin
            gnt_d[win] = 1'b1;
        end
        if (state == CMP) begin
            done_d[id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            id          <= '0;
            op_a        <= '0;
            op_b        <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.busy    <= 1'b0;
            bus.lesser  <= 1'b0;
            bus.greater <= 1'b0;
            bus.equal   <= 1'b0;
        end else begin
            bus.gnt  <= gnt_d;
            bus.done <= done_d;
            bus.busy <= busy_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        id   <= win;
                        op_a <= a_arr[win];
                        op_b <= b_arr[win];
                    end
                end
                CMP: begin
                    bus.lesser  <= (op_a < op_b);
                    bus.greater <= (op_a > op_b);
                    bus.equal   <= (op_a == op_b);
                end
                RESP: ptr <= ptr_next;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: a schedule-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cmp_arbiter;
    localparam int unsigned N    = 16;
    localparam int unsigned NREQ = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cmp_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();
    cmp_arbiter #(.N(N), .NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample at cycle-count e schedules gnt in cycle e, done in e+1,
    // and the next sampling opportunity at e+3.
    int cyc     = 0;
    int next_ok = 0;
    int gnt_cyc = -100;
    int m_ptr   = 0;
    int m_win   = 0;
    int mw;
    logic [N-1:0] ma, mb;
    logic [2:0] old_f = 3'b000;
    logic [2:0] new_f = 3'b000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            next_ok = 0;
            gnt_cyc = -100;
            m_ptr   = 0;
            m_win   = 0;
            old_f   = 3'b000;
            new_f   = 3'b000;
        end else begin
            cyc++;
            if (cyc >= next_ok && bus.req != '0) begin
                mw = -1;
                for (int k = 0; k < NREQ; k++) begin
                    if (mw < 0 && bus.req[(m_ptr + k) % NREQ]) mw = (m_ptr + k) % NREQ;
                end
                ma      = bus.a_in[mw*N +: N];
                mb      = bus.b_in[mw*N +: N];
                old_f   = new_f;
                new_f   = {ma < mb, ma > mb, ma == mb};
                m_win   = mw;
                gnt_cyc = cyc;
                next_ok = cyc + 3;
                m_ptr   = (mw + 1) % NREQ;
            end
        end
    end

    logic [NREQ-1:0] one = 1;
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_busy;
    logic [2:0]      e_f;

    always @(negedge clk) begin
        e_gnt  = (cyc == gnt_cyc)     ? (one << m_win) : '0;
        e_done = (cyc == gnt_cyc + 1) ? (one << m_win) : '0;
        e_busy = (cyc == gnt_cyc) || (cyc == gnt_cyc + 1);
        e_f    = (cyc >= gnt_cyc + 1) ? new_f : old_f;
        check("model_gnt", bus.gnt, e_gnt);
        check("model_done", bus.done, e_done);
        check("model_busy", bus.busy, e_busy);
        check("model_flags", {bus.lesser, bus.greater, bus.equal}, e_f);
    end

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.a_in[i*N +: N] = a;
        bus.b_in[i*N +: N] = b;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.gnt == '0 && n < 10);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done == '0 && n < 10);
    endtask

    task automatic serve(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] ef, input string tag);
        int n;
        set_ops(i, a, b);
        bus.req[i] = 1'b1;
        wait_gnt(n);
        check({tag, "_gnt"}, bus.gnt, 32'(1) << i);
        bus.req[i] = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, bus.done, 32'(1) << i);
        check({tag, "_flags"}, {bus.lesser, bus.greater, bus.equal}, ef);
    endtask

    logic [N-1:0] ta [4] = '{16'd1, 16'd7, 16'd9, 16'd0};
    logic [N-1:0] tb [4] = '{16'd2, 16'd7, 16'd3, 16'hFFFF};
    logic [2:0]   tf [4] = '{3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        int n;
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_flags", {bus.lesser, bus.greater, bus.equal}, 0);
        rst = 1'b0;

        // reset while a compare is in flight
        set_ops(1, 16'd5, 16'd3);
        bus.req[1] = 1'b1;
        wait_gnt(n);
        check("rmid_gnt", bus.gnt, 4'b0010);
        check("rmid_busy", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rmid_gnt0", bus.gnt, 0);
        check("rmid_busy0", bus.busy, 0);
        check("rmid_flags0", {bus.lesser, bus.greater, bus.equal}, 0);
        bus.req = '0;
        @(negedge clk);
        check("rmid_nodone", bus.done, 0);
        set_ops(0, 16'd2, 16'd2);
        bus.req[0] = 1'b1;
        rst = 1'b0;
        wait_gnt(n);
        check("rmid_after_gnt", bus.gnt, 4'b0001);
        bus.req[0] = 1'b0;
        @(negedge clk);
        check("rmid_after_done", bus.done, 4'b0001);
        check("rmid_after_equal", bus.equal, 1);

        serve(2, 16'h0005, 16'h0003, 3'b010, "single");
        serve(0, 16'h0000, 16'hFFFF, 3'b100, "ext_lt");
        serve(0, 16'hFFFF, 16'hFFFF, 3'b001, "ext_eq");
        serve(0, 16'hFFFF, 16'h0000, 3'b010, "ext_gt");
        repeat (4) @(negedge clk);
        check("hold_greater", bus.greater, 1);
        check("hold_lesser", bus.lesser, 0);

        // all requesters held high from reset
        #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, ta[i], tb[i]);
        bus.req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_done(n);
            check("all_done", bus.done, 32'(1) << (k % 4));
            check("all_flags", {bus.lesser, bus.greater, bus.equal}, tf[k % 4]);
            if (k > 0) check("all_gap", n, 3);
        end

        // fairness between requesters 1 and 3, then 1 alone
        #2 rst = 1'b1;
        bus.req = 4'b1010;
        set_ops(1, 16'd3, 16'd8);
        set_ops(3, 16'd8, 16'd3);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(n);
            check("fair_gnt", bus.gnt, (k % 2 == 0) ? 4'b0010 : 4'b1000);
            if (k > 0) check("fair_gap", n, 3);
            if (k == 3) bus.req[3] = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            wait_gnt(n);
            check("solo_gnt", bus.gnt, 4'b0010);
            check("solo_gap", n, 3);
        end
        bus.req = '0;
        repeat (4) @(negedge clk);

        // operand change after capture must not affect the result
        set_ops(1, 16'd9, 16'd4);
        bus.req[1] = 1'b1;
        wait_gnt(n);
        check("late_gnt", bus.gnt, 4'b0010);
        set_ops(1, 16'd1, 16'd4);
        bus.req[1] = 1'b0;
        @(negedge clk);
        check("late_done", bus.done, 4'b0010);
        check("late_greater", bus.greater, 1);
        check("late_lesser", bus.lesser, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
